// File: rtl/seven_segment_mux.sv
// Time-multiplexed common-anode seven-segment driver: binary value in, sequential
// double-dabble to BCD, atomic commit to the display, then digit-by-digit scanning.
module seven_segment_mux #(
   parameter int DIGITS   = 4,
   parameter int VAL_W    = 14,
   parameter int SCAN_DIV = 131072
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [VAL_W-1:0]  value,
   input  logic [DIGITS-1:0] dp_in,
   input  logic              blank_lz,
   output logic              busy,
   output logic              overflow,
   output logic [6:0]        seg,
   output logic              dp,
   output logic [DIGITS-1:0] an
);

   function automatic logic [31:0] pow10(input int n);
      logic [31:0] r;
      r = 32'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 32'd10;
      end
      return r;
   endfunction

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    glyph = 7'b1000000;
         4'd1:    glyph = 7'b1111001;
         4'd2:    glyph = 7'b0100100;
         4'd3:    glyph = 7'b0110000;
         4'd4:    glyph = 7'b0011001;
         4'd5:    glyph = 7'b0010010;
         4'd6:    glyph = 7'b0000010;
         4'd7:    glyph = 7'b1111000;
         4'd8:    glyph = 7'b0000000;
         4'd9:    glyph = 7'b0010000;
         default: glyph = 7'b1111111;
      endcase
   endfunction

   localparam int          BCD_W = 4 * DIGITS;
   localparam int          IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int          CNT_W = $clog2(SCAN_DIV);
   localparam int          BIT_W = $clog2(VAL_W + 1);
   localparam logic [31:0] LIMIT = pow10(DIGITS);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // conversion state
   logic              busy_q,     busy_d;
   logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
   logic [VAL_W-1:0]  bin_q,      bin_d;
   logic [BCD_W-1:0]  bcd_q,      bcd_d;
   logic [DIGITS-1:0] dp_cap_q,   dp_cap_d;
   logic              ovf_pend_q, ovf_pend_d;

   // committed display state
   logic [BCD_W-1:0]  disp_q,     disp_d;
   logic [DIGITS-1:0] disp_dp_q,  disp_dp_d;
   logic              ovf_q,      ovf_d;

   // scan state and registered pins
   logic [CNT_W-1:0]  scan_q,     scan_d;
   logic [IDX_W-1:0]  idx_q,      idx_d;
   logic [6:0]        seg_q,      seg_d;
   logic              dp_q,       dp_d;
   logic [DIGITS-1:0] an_q,       an_d;

   logic [BCD_W-1:0]  bcd_adj;
   logic [DIGITS:0]   hi_zero;
   logic [3:0]        cur_nib;
   logic              blank_sel;

   // Add 3 to every nibble of 5 or more so the following left shift carries correctly.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end else begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
         end
      end
   end

   // Capture, shift and commit sequencing of the converter.
   always_comb begin
      busy_d     = busy_q;
      bit_cnt_d  = bit_cnt_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      dp_cap_d   = dp_cap_q;
      ovf_pend_d = ovf_pend_q;
      disp_d     = disp_q;
      disp_dp_d  = disp_dp_q;
      ovf_d      = ovf_q;
      if (busy_q) begin
         if (bit_cnt_q == BIT_W'(VAL_W)) begin
            // every bit shifted in: publish result, dp and overflow on one edge
            disp_d    = bcd_q;
            disp_dp_d = dp_cap_q;
            ovf_d     = ovf_pend_q;
            busy_d    = 1'b0;
         end else begin
            bcd_d     = BCD_W'({bcd_adj, bin_q[VAL_W-1]});
            bin_d     = bin_q << 1;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
         end
      end else if (load) begin
         busy_d     = 1'b1;
         bit_cnt_d  = {BIT_W{1'b0}};
         bin_d      = value;
         bcd_d      = {BCD_W{1'b0}};
         dp_cap_d   = dp_in;
         ovf_pend_d = ({{(32-VAL_W){1'b0}}, value} >= LIMIT);
      end else begin
         busy_d = 1'b0;
      end
   end

   // Slot counter and digit index; index advances when the slot counter wraps.
   always_comb begin
      scan_d = scan_q;
      idx_d  = idx_q;
      if (scan_q == CNT_W'(SCAN_DIV - 1)) begin
         scan_d = {CNT_W{1'b0}};
         if (idx_q == IDX_W'(DIGITS - 1)) begin
            idx_d = {IDX_W{1'b0}};
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end else begin
         scan_d = scan_q + CNT_W'(1);
      end
   end

   // Glyph, decimal point and anode for the digit currently selected by idx.
   always_comb begin
      hi_zero[DIGITS] = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         hi_zero[i] = hi_zero[i+1] && (disp_q[4*i +: 4] == 4'd0);
      end
      cur_nib   = disp_q[4*idx_q +: 4];
      blank_sel = blank_lz && (idx_q != IDX_W'(0)) && hi_zero[idx_q];
      an_d      = ~(DIGITS'(1) << idx_q);
      seg_d     = SEG_BLANK;
      dp_d      = 1'b1;
      if (ovf_q) begin
         seg_d = SEG_DASH;
         dp_d  = 1'b1;
      end else if (blank_sel) begin
         seg_d = SEG_BLANK;
         dp_d  = ~disp_dp_q[idx_q];
      end else begin
         seg_d = glyph(cur_nib);
         dp_d  = ~disp_dp_q[idx_q];
      end
   end

   // State register for converter, display and scan.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q     <= 1'b0;
         bit_cnt_q  <= {BIT_W{1'b0}};
         bin_q      <= {VAL_W{1'b0}};
         bcd_q      <= {BCD_W{1'b0}};
         dp_cap_q   <= {DIGITS{1'b0}};
         ovf_pend_q <= 1'b0;
         disp_q     <= {BCD_W{1'b0}};
         disp_dp_q  <= {DIGITS{1'b0}};
         ovf_q      <= 1'b0;
         scan_q     <= {CNT_W{1'b0}};
         idx_q      <= {IDX_W{1'b0}};
         seg_q      <= SEG_BLANK;
         dp_q       <= 1'b1;
         an_q       <= {DIGITS{1'b1}};
      end else begin
         busy_q     <= busy_d;
         bit_cnt_q  <= bit_cnt_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         dp_cap_q   <= dp_cap_d;
         ovf_pend_q <= ovf_pend_d;
         disp_q     <= disp_d;
         disp_dp_q  <= disp_dp_d;
         ovf_q      <= ovf_d;
         scan_q     <= scan_d;
         idx_q      <= idx_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         an_q       <= an_d;
      end
   end

   assign busy     = busy_q;
   assign overflow = ovf_q;
   assign seg      = seg_q;
   assign dp       = dp_q;
   assign an       = an_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Directed + randomized bench for seven_segment_mux; expected pins come from a
// decimal-arithmetic model of the displayed number and the scan position.
module tb_seven_segment_mux;
   localparam int DIGITS   = 4;
   localparam int VAL_W    = 14;
   localparam int SCAN_DIV = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic [13:0] value = 14'd0;
   logic [3:0]  dp_in = 4'd0;
   logic        blank_lz = 1'b0;
   logic        busy, overflow, dp;
   logic [6:0]  seg;
   logic [3:0]  an;

   seven_segment_mux #(.DIGITS(DIGITS), .VAL_W(VAL_W), .SCAN_DIV(SCAN_DIV)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
      .blank_lz(blank_lz), .busy(busy), .overflow(overflow), .seg(seg), .dp(dp), .an(an)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // model state: what number is shown, and where the scan is
   int         m_left, m_pend_val, m_disp_val, m_cycle;
   logic [3:0] m_pend_dp, m_disp_dp;
   logic       m_ovf;

   function automatic int p10(input int n);
      int r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [6:0] glyph_of(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_left = 0; m_disp_val = 0; m_disp_dp = 4'd0; m_ovf = 1'b0; m_cycle = 0;
      m_pend_val = 0; m_pend_dp = 4'd0;
   endtask

   // One clock: predict from pre-edge state/inputs, advance model, compare after the edge.
   task automatic tick();
      logic [6:0] e_seg;
      logic       e_dp;
      logic [3:0] e_an;
      int         i, d;
      if (!rst_n) begin
         model_reset();
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
         i    = (m_cycle / SCAN_DIV) % DIGITS;
         e_an = ~(4'b0001 << i);
         if (m_ovf) begin
            e_seg = 7'b0111111; e_dp = 1'b1;
         end else begin
            d = (m_disp_val / p10(i)) % 10;
            if (blank_lz && i > 0 && m_disp_val < p10(i)) e_seg = 7'b1111111;
            else e_seg = glyph_of(d);
            e_dp = ~m_disp_dp[i];
         end
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_disp_val = m_pend_val;
               m_disp_dp  = m_pend_dp;
               m_ovf      = (m_pend_val >= p10(DIGITS));
            end
         end else if (load) begin
            m_left     = VAL_W + 1;
            m_pend_val = int'(value);
            m_pend_dp  = dp_in;
         end
         m_cycle++;
      end
      @(posedge clk);
      @(negedge clk);
      chk("an", 7'(an), 7'(e_an));
      chk("seg", seg, e_seg);
      chk("dp", 7'(dp), 7'(e_dp));
      chk("busy", 7'(busy), 7'(m_left > 0));
      chk("overflow", 7'(overflow), 7'(m_ovf));
   endtask

   task automatic do_load(input int v, input logic [3:0] d);
      value = 14'(v); dp_in = d; load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   // Bounded wait for conversion end plus one edge so the commit reaches the pins.
   task automatic wait_idle();
      int k = 0;
      while (busy && k < 40) begin tick(); k++; end
      chk("idle_timeout", 7'(busy), 7'd0);
      tick();
   endtask

   task automatic find_digit(input string tag, input logic [3:0] t_an,
                             input logic [6:0] t_seg, input logic t_dp);
      int k = 0;
      while (an !== t_an && k < 32) begin tick(); k++; end
      chk({tag, "_an"}, 7'(an), 7'(t_an));
      chk({tag, "_seg"}, seg, t_seg);
      chk({tag, "_dp"}, 7'(dp), 7'(t_dp));
   endtask

   task automatic async_reset_check(input string tag);
      #2 rst_n = 1'b0;
      #1;
      chk({tag, "_an"}, 7'(an), 7'h0F);
      chk({tag, "_seg"}, seg, 7'h7F);
      chk({tag, "_dp"}, 7'(dp), 7'd1);
      chk({tag, "_busy"}, 7'(busy), 7'd0);
      chk({tag, "_ovf"}, 7'(overflow), 7'd0);
      load = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int c;
      model_reset();
      // reset and release
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("rel_an", 7'(an), 7'(4'b1110));
      chk("rel_seg", seg, 7'b1000000);
      repeat (5) tick();
      async_reset_check("async_rst");
      tick();

      // conversion of 1234 and busy length
      blank_lz = 1'b0;
      do_load(1234, 4'b0100);
      c = 1;
      while (busy && c < 40) begin tick(); if (busy) c++; end
      chk("busy_len_1234", 7'(c), 7'd15);
      tick();
      find_digit("d0_1234", 4'b1110, 7'b0011001, 1'b1);
      find_digit("d1_1234", 4'b1101, 7'b0110000, 1'b1);
      find_digit("d2_1234", 4'b1011, 7'b0100100, 1'b0);
      find_digit("d3_1234", 4'b0111, 7'b1111001, 1'b1);

      // leading-zero blanking
      blank_lz = 1'b1;
      do_load(7, 4'b0000);
      wait_idle();
      find_digit("lz_d3", 4'b0111, 7'b1111111, 1'b1);
      find_digit("lz_d2", 4'b1011, 7'b1111111, 1'b1);
      find_digit("lz_d1", 4'b1101, 7'b1111111, 1'b1);
      find_digit("lz_d0", 4'b1110, 7'b1111000, 1'b1);
      blank_lz = 1'b0;
      tick();
      find_digit("nolz_d1", 4'b1101, 7'b1000000, 1'b1);
      find_digit("nolz_d3", 4'b0111, 7'b1000000, 1'b1);

      // overflow then recovery
      do_load(10000, 4'b1111);
      wait_idle();
      chk("ovf_set", 7'(overflow), 7'd1);
      find_digit("ovf_d2", 4'b1011, 7'b0111111, 1'b1);
      find_digit("ovf_d0", 4'b1110, 7'b0111111, 1'b1);
      do_load(9999, 4'b0000);
      wait_idle();
      chk("ovf_clr", 7'(overflow), 7'd0);
      find_digit("n9999_d0", 4'b1110, 7'b0010000, 1'b1);
      find_digit("n9999_d3", 4'b0111, 7'b0010000, 1'b1);

      // load while busy is dropped
      do_load(42, 4'b0000);
      c = 1;
      repeat (4) begin tick(); if (busy) c++; end
      value = 14'd99; load = 1'b1;
      tick(); if (busy) c++;
      load = 1'b0;
      while (busy && c < 40) begin tick(); if (busy) c++; end
      chk("busy_len_42", 7'(c), 7'd15);
      tick();
      find_digit("n42_d0", 4'b1110, 7'b0100100, 1'b1);
      find_digit("n42_d1", 4'b1101, 7'b0011001, 1'b1);
      find_digit("n42_d2", 4'b1011, 7'b1000000, 1'b1);

      // reset in the middle of a conversion
      do_load(5678, 4'b0001);
      repeat (6) tick();
      async_reset_check("mid_rst");
      tick();
      chk("mid_rst_busy", 7'(busy), 7'd0);
      find_digit("mid_rst_d0", 4'b1110, 7'b1000000, 1'b1);
      find_digit("mid_rst_d3", 4'b0111, 7'b1000000, 1'b1);
      do_load(5678, 4'b0000);
      wait_idle();
      find_digit("n5678_d0", 4'b1110, 7'b0000000, 1'b1);
      find_digit("n5678_d1", 4'b1101, 7'b1111000, 1'b1);
      find_digit("n5678_d2", 4'b1011, 7'b0000010, 1'b1);
      find_digit("n5678_d3", 4'b0111, 7'b0010010, 1'b1);

      // back-to-back: load held high continuously
      load = 1'b1;
      repeat (50) begin
         value = 14'($urandom_range(0, 9999));
         dp_in = 4'($urandom_range(0, 15));
         tick();
      end
      load = 1'b0;

      // random loads, live blank_lz changes, ignored dp_in/value wiggle
      repeat (700) begin
         case ($urandom_range(0, 2))
            0:       value = 14'($urandom_range(0, 150));
            1:       value = 14'($urandom_range(0, 9999));
            default: value = 14'($urandom_range(0, 16383));
         endcase
         dp_in = 4'($urandom_range(0, 15));
         load  = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 7) == 0) blank_lz = ~blank_lz;
         tick();
      end
      load = 1'b0;
      repeat (20) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/seven_segment_mux.md
# seven_segment_mux

Parametrised, time-multiplexed seven-segment display driver for DIGITS common-anode digits. It accepts a binary value on a load strobe and converts it to BCD with a sequential double-dabble engine. The result is displayed atomically with optional leading-zero blanking, per-digit decimal points and overflow indication. It sits between the control logic and the board display pins, and is the generalised successor to the fixed 2-digit `seven_segment` driver.

## Interface
Parameters:
- DIGITS, 4, number of digits scanned; legal range 1..8.
- VAL_W, 14, width of `value`; legal range 1..27.
- SCAN_DIV, 131072, clocks per digit slot; must be ≥ 2.

Ports:
- clk  in  1  system clock; all state on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- load  in  1  sampled each clock; accepted only when `busy`=0.
- value  in  VAL_W  unsigned binary to display; captured on accepted load.
- dp_in  in  DIGITS  decimal-point enables, bit i → digit i; captured on accepted load.
- blank_lz  in  1  leading-zero blanking enable; used live.
- busy  out  1  conversion in progress.
- overflow  out  1  last accepted value ≥ 10^DIGITS.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp  out  1  decimal point, active-low, registered.
- an  out  DIGITS  anode selects, one-hot active-low, registered.

## Operation
- **Accept:** `load`=1 and `busy`=0 at an edge captures `value` and `dp_in` and sets `busy`. If `load` arrives while `busy`=1, it is ignored without queuing.
- **Conversion:** shift-add-3 double-dabble. The binary shift register is VAL_W bits and the BCD register is DIGITS nibbles.
  - One bit is processed per clock, for VAL_W shift cycles.
  - Each nibble ≥ 5 gets +3 before the shift.
- **Overflow:** decided at capture by comparing `value` against the constant 10^DIGITS.
- **Commit:** on the edge ending conversion, all of the following update together:
  - the BCD nibbles are copied into the display register;
  - the captured dp bits are copied into the display dp register;
  - `overflow` is updated;
  - `busy` clears.
  The display never shows a partial conversion.
- **Scan:**
  - A counter runs 0..SCAN_DIV-1. On wrap, digit index `idx` increments mod DIGITS, so digit 0 follows digit DIGITS-1.
  - Each clock, `an`, `seg` and `dp` are registered from the current `idx`. `an` and `seg` therefore always change on the same edge.
- **Encoding** (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111, dash=0111111
- **Blanking:** digit i (i ≥ 1) shows blank when `blank_lz`=1 and display digits i..DIGITS-1 are all zero. Digit 0 is never blanked. A blanked digit still drives its own dp.
- **Overflow display:** every digit shows dash with dp off until a later accepted load has value < 10^DIGITS.

## Timing
- **Reset (async assert):**
  - `an` = all ones, `seg` = 1111111, `dp` = 1
  - `busy` = 0, `overflow` = 0
  - display digits and dp register = 0
  - `idx` = 0, scan counter = 0
- **First clock after reset release:** `an[0]`=0, `seg` = glyph 0.
- **Latency:**
  - Load accepted at edge k: `busy`=1 after edge k, for exactly VAL_W+1 clocks. It falls after edge k+VAL_W+1, which is the commit edge.
  - New glyphs appear on `seg` at the first edge after commit where the digit is selected.
- **Back-to-back loads:** a second load may be accepted on the edge immediately after `busy` falls.
- **Reset mid-conversion:** the conversion is abandoned and all state returns to reset values.
- **Scan period:** DIGITS×SCAN_DIV clocks. Each digit is active for exactly SCAN_DIV consecutive clocks, with no all-off gap.
- **Live inputs:** a `blank_lz` change takes effect on the next edge; `dp_in` changes are ignored outside accepted loads.

## Test plan
All scenarios use DIGITS=4, VAL_W=14, SCAN_DIV=4.
- **Reset value:** hold `rst_n`=0, then release → `an`=1110, `seg`=1000000, `dp`=1, `busy`=0. Assert `rst_n` asynchronously mid-clock → outputs return to reset values immediately.
- **Conversion:** load 1234, `dp_in`=0100, `blank_lz`=0 → `busy` high for 15 clocks. Then, over one 16-clock scan:
  - `an`=1110 shows 0011001 (4);
  - `an`=1101 shows 0110000 (3);
  - `an`=1011 shows 0100100 (2) with `dp`=0;
  - `an`=0111 shows 1111001 (1).
- **Leading-zero blanking:** load 7 with `blank_lz`=1 → digits 3..1 show 1111111 and digit 0 shows 1111000. Set `blank_lz`=0 → digits 3..1 show 1000000 from the next edge.
- **Overflow:** load 10000 → `overflow`=1 and all digits show 0111111. Then load 9999 → `overflow`=0 and 9999 is displayed.
- **Load ignored while busy:** load 42, then pulse load with 99 five clocks later → display shows 0042; `busy` stays high for exactly 15 clocks.
- **Reset mid-conversion:** pulse `rst_n` low 6 clocks after loading 5678 → display remains 0000 and `busy`=0; a fresh load of 5678 then converts correctly.
